// File: rtl/radix2_div32.sv
// Iterative restoring divider: one quotient bit per cycle, RISC-V DIV/DIVU/REM/REMU
// semantics, start/finished handshake shared with the multiplier.
module radix2_div32 #(
  parameter int WIDTH    = 32,
  parameter int CNT_BITS = 6
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  input  logic             start,
  output logic             busy,
  output logic             finished,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CNT_BITS-1:0] LAST = CNT_BITS'(WIDTH - 1);

  logic [1:0]          state;
  logic [WIDTH-1:0]    dvd;
  logic [WIDTH-1:0]    dvs;
  logic [WIDTH:0]      rem;
  logic [CNT_BITS-1:0] cnt;
  logic                neg_q;
  logic                neg_r;

  logic [WIDTH+1:0]    shifted;
  logic [WIDTH+1:0]    diff;
  logic                q_bit;
  logic [WIDTH:0]      rem_next;
  logic [WIDTH-1:0]    q_next;
  logic                dividend_neg;
  logic                divisor_neg;

  assign dividend_neg = is_signed & dividend[WIDTH-1];
  assign divisor_neg  = is_signed & divisor[WIDTH-1];

  // Trial subtraction one bit wider than the remainder so the borrow is the sign bit.
  always_comb begin
    shifted  = {rem, dvd[WIDTH-1]};
    diff     = shifted - {2'b00, dvs};
    q_bit    = ~diff[WIDTH+1];
    rem_next = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];
    q_next   = {dvd[WIDTH-2:0], q_bit};
  end

  assign busy     = (state == RUN);
  assign finished = (state == DONE);

  // A start in any state (re)captures operands; divide by zero needs no special path
  // because every trial subtract succeeds, giving all-ones and |dividend| as remainder.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      dvd       <= '0;
      dvs       <= '0;
      rem       <= '0;
      cnt       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else if (start) begin
      state <= RUN;
      dvd   <= dividend_neg ? -dividend : dividend;
      dvs   <= divisor_neg ? -divisor : divisor;
      rem   <= '0;
      cnt   <= '0;
      neg_q <= (dividend_neg ^ divisor_neg) & (divisor != '0);
      neg_r <= dividend_neg;
    end else begin
      case (state)
        RUN: begin
          rem <= rem_next;
          dvd <= q_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state     <= DONE;
            quotient  <= neg_q ? -q_next : q_next;
            remainder <= neg_r ? -rem_next[WIDTH-1:0] : rem_next[WIDTH-1:0];
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
